// File: rtl/complex_adaptive_kalman_pkg.sv
// Shared fixed-point defaults and FSM state encoding for the complex_adaptive_kalman blocks.
package complex_adaptive_kalman_pkg;

  localparam int CAK_FXP_WIDTH     = 16;
  localparam int CAK_FXP_FRAC      = 12;
  localparam int CAK_FILTER_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ROUND,
    HOLD
  } mac_state_e;

  function automatic int tapBusWidth(input int filterLength, input int fxpWidth);
    return filterLength * fxpWidth;
  endfunction

  // Two full-width products plus enough guard bits for every tap to add without overflow.
  function automatic int accWidth(input int fxpWidth, input int filterLength);
    return 2 * fxpWidth + ((filterLength > 1) ? $clog2(filterLength) : 1);
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Rounds a wide fixed-point accumulator half-up to FXP_WIDTH bits and clamps to the signed range.
module fxp_round_sat
  import complex_adaptive_kalman_pkg::*;
#(
  parameter int FXP_WIDTH = CAK_FXP_WIDTH,
  parameter int FXP_FRAC  = CAK_FXP_FRAC,
  parameter int ACC_W     = accWidth(CAK_FXP_WIDTH, CAK_FILTER_LENGTH)
) (
  input  logic signed [ACC_W-1:0]     acc_i,
  output logic signed [FXP_WIDTH-1:0] value_o,
  output logic                        sat_o
);

  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(64'sd1 <<< (FXP_FRAC - 1));
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (FXP_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  // The accumulator carries guard bits, so adding the half-LSB constant cannot wrap.
  always_comb begin
    rounded = acc_i + RND;
    shifted = rounded >>> FXP_FRAC;
    value_o = shifted[FXP_WIDTH-1:0];
    sat_o   = 1'b0;
    if (shifted > MAX_V) begin
      value_o = MAX_V[FXP_WIDTH-1:0];
      sat_o   = 1'b1;
    end else if (shifted < MIN_V) begin
      value_o = MIN_V[FXP_WIDTH-1:0];
      sat_o   = 1'b1;
    end
  end

endmodule

// File: rtl/output_feedback_mac.sv
// Output-feedback dot product: one multiply-accumulate per cycle over a snapshot of the
// output history and coefficients, followed by round/saturate and a held valid/ready result.
module output_feedback_mac
  import complex_adaptive_kalman_pkg::*;
#(
  parameter int FXP_WIDTH     = CAK_FXP_WIDTH,
  parameter int FXP_FRAC      = CAK_FXP_FRAC,
  parameter int FILTER_LENGTH = CAK_FILTER_LENGTH,
  parameter int TAP_BUS_WIDTH = tapBusWidth(FILTER_LENGTH, FXP_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TAP_BUS_WIDTH-1:0]    taps_in,
  input  logic [TAP_BUS_WIDTH-1:0]    coef_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [FXP_WIDTH-1:0] out_sample,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sat_flag
);

  localparam int ACC_W = accWidth(FXP_WIDTH, FILTER_LENGTH);
  localparam int IDX_W = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FILTER_LENGTH - 1);

  mac_state_e state_q, state_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [TAP_BUS_WIDTH-1:0]    taps_q, taps_d;
  logic [TAP_BUS_WIDTH-1:0]    coef_q, coef_d;
  logic signed [FXP_WIDTH-1:0] out_q, out_d;
  logic                        sat_q, sat_d;

  logic signed [FXP_WIDTH-1:0]   tapCur;
  logic signed [FXP_WIDTH-1:0]   coefCur;
  logic signed [2*FXP_WIDTH-1:0] prod;
  logic signed [FXP_WIDTH-1:0]   rndValue;
  logic                          rndSat;

  assign tapCur  = taps_q[idx_q*FXP_WIDTH +: FXP_WIDTH];
  assign coefCur = coef_q[idx_q*FXP_WIDTH +: FXP_WIDTH];
  assign prod    = tapCur * coefCur;

  fxp_round_sat #(
    .FXP_WIDTH (FXP_WIDTH),
    .FXP_FRAC  (FXP_FRAC),
    .ACC_W     (ACC_W)
  ) u_round_sat (
    .acc_i   (acc_q),
    .value_o (rndValue),
    .sat_o   (rndSat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      taps_q  <= '0;
      coef_q  <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      taps_q  <= taps_d;
      coef_q  <= coef_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  // HOLD only releases back to IDLE, so a job can never be accepted on the handshake edge.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    taps_d  = taps_q;
    coef_d  = coef_q;
    out_d   = out_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          taps_d  = taps_in;
          coef_d  = coef_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_W'(prod);
        if (idx_q == LAST_IDX) begin
          state_d = ROUND;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ROUND: begin
        out_d   = rndValue;
        sat_d   = rndSat;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == HOLD);
  assign out_sample = out_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_output_feedback_mac.sv
// Directed bench for output_feedback_mac: a table of dot-product jobs plus hand-written
// sequences for backpressure, input changes during accumulation and reset mid-job.
module tb_output_feedback_mac;

  localparam int W   = 16;
  localparam int L   = 16;
  localparam int TBW = W * L;
  localparam int NV  = 8;
  // The accepting edge counts as edge 1, so the result is held from edge L+2 onward.
  localparam int EXP_LAT = L + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [TBW-1:0]      taps_in;
  logic [TBW-1:0]      coef_in;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] out_sample;
  logic                out_valid;
  logic                out_ready;
  logic                sat_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string               name;
    logic [TBW-1:0]      taps;
    logic [TBW-1:0]      coef;
    logic signed [W-1:0] expOut;
    logic                expSat;
  } vec_t;

  vec_t vecs[NV];

  output_feedback_mac #(
    .FXP_WIDTH     (W),
    .FXP_FRAC      (12),
    .FILTER_LENGTH (L),
    .TAP_BUS_WIDTH (TBW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .taps_in    (taps_in),
    .coef_in    (coef_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [TBW-1:0] fillBus(input int v);
    logic [TBW-1:0] b;
    for (int m = 0; m < L; m++) b[m*W +: W] = W'(v);
    return b;
  endfunction

  // Called at a negedge: waits for in_ready, presents the job and returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [TBW-1:0] t, input logic [TBW-1:0] c);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("in_ready before accept", in_ready, 1);
    taps_in  = t;
    coef_in  = c;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready during ACCUM", in_ready, 0);
    check("out_valid after accept", out_valid, 0);
  endtask

  task automatic waitOutput(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input logic signed [W-1:0] expOut,
                             input logic expSat);
    check({name, " out_valid"}, out_valid, 1);
    check({name, " out_sample"}, out_sample, expOut);
    check({name, " sat_flag"}, sat_flag, expSat);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid after handshake"}, out_valid, 0);
    check({name, " in_ready after handshake"}, in_ready, 1);
  endtask

  initial begin
    logic [TBW-1:0] t;
    logic [TBW-1:0] c;
    int lat;
    int seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    taps_in   = '0;
    coef_in   = '0;

    // Unit tap, coefficient only on the newest tap: 1.0.
    t = fillBus(4096); c = '0; c[0 +: W] = 16'sd4096;
    vecs[0] = '{"unit", t, c, 16'sd4096, 1'b0};
    // Sum 16.0 saturates high; negated coefficients saturate low.
    vecs[1] = '{"satHigh", fillBus(4096), fillBus(4096), 16'sd32767, 1'b1};
    vecs[2] = '{"satLow", fillBus(4096), fillBus(-4096), -16'sd32768, 1'b1};
    // Exact half-LSB ties round toward +inf.
    t = '0; c = '0; t[0 +: W] = 16'sd1; c[0 +: W] = 16'sd2048;
    vecs[3] = '{"roundPos", t, c, 16'sd1, 1'b0};
    t[0 +: W] = -16'sd1;
    vecs[4] = '{"roundNeg", t, c, 16'sd0, 1'b0};
    // 2.0 * -1.5 on tap 3 plus 1.0 * 0.5 on the last tap = -2.5 -> -10240.
    t = '0; c = '0;
    t[3*W +: W] = 16'sd8192;  c[3*W +: W] = -16'sd6144;
    t[15*W +: W] = 16'sd4096; c[15*W +: W] = 16'sd2048;
    vecs[5] = '{"mixed", t, c, -16'sd10240, 1'b0};
    // -3 * 0.5 = -1.5 LSB -> -1; 3 * 0.5 = 1.5 LSB -> 2.
    t = '0; c = '0; t[0 +: W] = -16'sd3; c[0 +: W] = 16'sd2048;
    vecs[6] = '{"roundNeg3", t, c, -16'sd1, 1'b0};
    t[0 +: W] = 16'sd3;
    vecs[7] = '{"roundPos3", t, c, 16'sd2, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_sample", out_sample, 0);
    check("reset sat_flag", sat_flag, 0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].taps, vecs[i].coef);
      waitOutput(lat);
      check({vecs[i].name, " latency"}, lat, EXP_LAT);
      checkOutput(vecs[i].name, vecs[i].expOut, vecs[i].expSat);
    end

    // Backpressure: result held while out_ready is low and new jobs are refused.
    applyStimulus(vecs[0].taps, vecs[0].coef);
    waitOutput(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      taps_in  = fillBus(i * 100 + 7);
      coef_in  = fillBus(4096);
      @(posedge clk);
      @(negedge clk);
      check("bp out_sample stable", out_sample, 4096);
      check("bp out_valid held", out_valid, 1);
      check("bp in_ready low", in_ready, 0);
    end
    checkOutput("bp release", 16'sd4096, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp no accept on handshake edge", in_ready, 1);

    // Inputs scrambled during ACCUM must not affect the snapshot.
    applyStimulus(vecs[5].taps, vecs[5].coef);
    for (int i = 0; i < L; i++) begin
      taps_in = {8{$urandom()}};
      coef_in = {8{$urandom()}};
      @(posedge clk);
      @(negedge clk);
    end
    waitOutput(lat);
    checkOutput("snapshot", -16'sd10240, 1'b0);

    // Reset with the index at 7, with in_valid also high to show reset wins.
    applyStimulus(vecs[1].taps, vecs[1].coef);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort out_sample", out_sample, 0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort no out_valid pulse", seen, 0);
    applyStimulus(vecs[1].taps, vecs[1].coef);
    waitOutput(lat);
    check("after abort latency", lat, EXP_LAT);
    checkOutput("after abort", 16'sd32767, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
